reg_bank: RTL and testbench

REG_BANK -- requirements
Module: reg_bank

---
 rtl/reg_bank.sv | 47 ++++
 tb/tb_reg_bank.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/reg_bank.sv
// Register bank: mem_depth words of size bits, two combinational read ports, one write port.
// Register 0 and any address at or above mem_depth read as zero and ignore writes.
module reg_bank #(
    parameter int unsigned size      = 32,
    parameter int unsigned mem_depth = 32  // at most 32: addresses are 5 bits
) (
    input  logic            CLK,
    input  logic            aRSTn,      // synchronous, active-high
    input  logic            ENA_WRITE,
    input  logic [4:0]      WRITE_REG,
    input  logic [size-1:0] WRITE_DATA,
    input  logic [4:0]      READREG_1,
    input  logic [4:0]      READREG_2,
    output logic [size-1:0] read_data1,
    output logic [size-1:0] read_data2
);

    // Full 32-entry view so every 5-bit address decodes; unbacked entries are tied to zero.
    logic [size-1:0] regs [32];

    for (genvar g = 0; g < 32; g++) begin : g_reg
        if (g == 0 || g >= int'(mem_depth)) begin : g_zero
            assign regs[g] = '0;
        end else begin : g_store
            logic [size-1:0] word_q;
            logic            wr_en;

            assign wr_en = ENA_WRITE && (WRITE_REG == 5'(g));

            // Reset wins over a write in the same cycle.
            always_ff @(posedge CLK) begin
                if (aRSTn) begin
                    word_q <= '0;
                end else if (wr_en) begin
                    word_q <= WRITE_DATA;
                end
            end

            assign regs[g] = word_q;
        end
    end

    // No bypass: a read in the write cycle sees the value from before the edge.
    assign read_data1 = regs[READREG_1];
    assign read_data2 = regs[READREG_2];

endmodule

// File: tb/tb_reg_bank.sv
// Self-checking bench for reg_bank: directed steps plus a randomized phase,
// compared against an array model of the register file.
module tb_reg_bank;

    logic        CLK = 1'b0;
    logic        aRSTn;
    logic        ENA_WRITE;
    logic [4:0]  WRITE_REG;
    logic [31:0] WRITE_DATA;
    logic [4:0]  READREG_1;
    logic [4:0]  READREG_2;
    logic [31:0] read_data1;
    logic [31:0] read_data2;

    int total = 0;
    int bad   = 0;

    // Reference contents; index 0 is never written.
    logic [31:0] model [32];

    reg_bank #(
        .size      (32),
        .mem_depth (32)
    ) dut (
        .CLK        (CLK),
        .aRSTn      (aRSTn),
        .ENA_WRITE  (ENA_WRITE),
        .WRITE_REG  (WRITE_REG),
        .WRITE_DATA (WRITE_DATA),
        .READREG_1  (READREG_1),
        .READREG_2  (READREG_2),
        .read_data1 (read_data1),
        .read_data2 (read_data2)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Apply one rising edge and advance the model by the architectural rule.
    task automatic tick();
        @(posedge CLK);
        if (aRSTn === 1'b1) begin
            for (int i = 0; i < 32; i++) model[i] = 32'h0;
        end else if (ENA_WRITE === 1'b1 && WRITE_REG != 5'd0) begin
            model[WRITE_REG] = WRITE_DATA;
        end
        #1;
    endtask

    task automatic rd(input string tag, input logic [4:0] a, input logic [4:0] b);
        READREG_1 = a;
        READREG_2 = b;
        #1;
        check({tag, "_p1"}, read_data1, model[a]);
        check({tag, "_p2"}, read_data2, model[b]);
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        ENA_WRITE  = 1'b1;
        WRITE_REG  = a;
        WRITE_DATA = d;
        tick();
        ENA_WRITE  = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        for (int i = 0; i < 32; i++) begin
            READREG_1 = 5'(i);
            READREG_2 = 5'(31 - i);
            #1;
            check({tag, "_p1"}, read_data1, 32'h0);
            check({tag, "_p2"}, read_data2, 32'h0);
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
        aRSTn      = 1'b1;
        ENA_WRITE  = 1'b1;
        WRITE_REG  = 5'd7;
        WRITE_DATA = 32'h1234_5678;
        READREG_1  = 5'd0;
        READREG_2  = 5'd0;

        // Reset held for two edges, with a write pending that must be discarded.
        tick();
        tick();
        aRSTn     = 1'b0;
        ENA_WRITE = 1'b0;
        check_all_zero("reset");

        // Write then read, zero latency.
        for (int i = 1; i < 32; i++) wr(5'(i), 32'h1000_0000 + i);
        for (int i = 1; i < 32; i++) rd("wr_rd", 5'(i), 5'((i + 1) % 32));
        check("wr_rd_val5", model[5], 32'h1000_0005);

        // Register 0 stays zero.
        wr(5'd0, 32'hDEAD_BEEF);
        READREG_1 = 5'd0;
        #1;
        check("x0", read_data1, 32'h0);

        // Disabled write leaves reg 5 alone.
        ENA_WRITE  = 1'b0;
        WRITE_REG  = 5'd5;
        WRITE_DATA = 32'hFFFF_FFFF;
        tick();
        READREG_1 = 5'd5;
        #1;
        check("no_wr", read_data1, 32'h1000_0005);

        // Simultaneous reads and a write to another register.
        ENA_WRITE  = 1'b1;
        WRITE_REG  = 5'd10;
        WRITE_DATA = 32'hA5A5_A5A5;
        READREG_1  = 5'd10;
        READREG_2  = 5'd14;
        #1;
        check("rdw_old10", read_data1, 32'h1000_000A);
        READREG_1 = 5'd23;
        #1;
        check("sim_23_pre", read_data1, 32'h1000_0017);
        check("sim_14_pre", read_data2, 32'h1000_000E);
        tick();
        ENA_WRITE = 1'b0;
        check("sim_23_post", read_data1, 32'h1000_0017);
        check("sim_14_post", read_data2, 32'h1000_000E);
        READREG_1 = 5'd10;
        #1;
        check("rdw_new10", read_data1, 32'hA5A5_A5A5);

        // Randomized traffic including occasional resets.
        for (int n = 0; n < 300; n++) begin
            aRSTn      = ($urandom_range(0, 24) == 0);
            ENA_WRITE  = 1'($urandom);
            WRITE_REG  = 5'($urandom);
            WRITE_DATA = $urandom;
            rd("rnd_pre", 5'($urandom), WRITE_REG);
            tick();
            rd("rnd_post", WRITE_REG, 5'($urandom));
        end
        aRSTn = 1'b0;

        // Fill, then reset together with a write to reg 3.
        for (int i = 1; i < 32; i++) wr(5'(i), $urandom | 32'h1);
        rd("fill3", 5'd3, 5'd31);
        aRSTn      = 1'b1;
        ENA_WRITE  = 1'b1;
        WRITE_REG  = 5'd3;
        WRITE_DATA = 32'hCAFE_F00D;
        tick();
        aRSTn     = 1'b0;
        ENA_WRITE = 1'b0;
        check_all_zero("mid_reset");

        // Writes resume after reset release.
        wr(5'd3, 32'h0BAD_F00D);
        READREG_1 = 5'd3;
        #1;
        check("resume", read_data1, 32'h0BAD_F00D);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
